// File: rtl/sph_seq_pkg.sv
// rtl/sph_seq_pkg.sv - shared constants, state encoding and area type for the scan sequencer
package sph_seq_pkg;
   localparam int DEPTH    = 16;
   localparam int RADIUS_W = 16;
   localparam int AREA_W   = 26;
   localparam int IDX_W    = 4;
   localparam int CNT_W    = IDX_W + 1;

   typedef logic [AREA_W-1:0] area_t;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      OUTPUT,
      DONE
   } state_e;

   function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] c,
                                                  input logic [CNT_W-1:0] lim);
      return (c > lim) ? lim : c;
   endfunction
endpackage

// File: rtl/sph_radius_buf.sv
// rtl/sph_radius_buf.sv - radius register file, one write port and one asynchronous read port
// Contents survive reset so a reloaded scan can reuse the stored radii.
module sph_radius_buf #(
   parameter int DEPTH = 16,
   parameter int W     = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];
endmodule

// File: rtl/sph_scan_seq.sv
// rtl/sph_scan_seq.sv - walks the radius buffer through the conversion core, one result at a time
// Optional SPH_SEQ_ACCUM_EN adds a running total_area output summed over transferred results.
module sph_scan_seq
   import sph_seq_pkg::*;
#(
   parameter int DEPTH    = sph_seq_pkg::DEPTH,
   parameter int RADIUS_W = sph_seq_pkg::RADIUS_W,
   parameter int AREA_W   = sph_seq_pkg::AREA_W,
   parameter int TIMEOUT  = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [IDX_W-1:0]    wr_addr,
   input  logic [RADIUS_W-1:0] wr_data,
   input  logic                start,
   input  logic [CNT_W-1:0]    count,
   output logic                busy,
   output logic                done,
   output logic                err_timeout,
   output logic                core_en,
   output logic [RADIUS_W-1:0] core_radius,
   input  logic                core_rdy,
   input  logic [AREA_W-1:0]   core_area,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [AREA_W-1:0]   res_area,
`ifdef SPH_SEQ_ACCUM_EN
   output logic [AREA_W+3:0]   total_area,
`endif
   output logic [IDX_W-1:0]    res_idx
);
   localparam int TO_W = $clog2(TIMEOUT + 1);

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [TO_W-1:0]     wait_q, wait_d;
   logic                err_q, err_d;
   logic [AREA_W-1:0]   res_area_q, res_area_d;
   logic [IDX_W-1:0]    res_idx_q, res_idx_d;
   logic [RADIUS_W-1:0] radius_q, radius_d;
   logic [RADIUS_W-1:0] rd_data;
   logic [CNT_W-1:0]    start_cnt;
`ifdef SPH_SEQ_ACCUM_EN
   logic [AREA_W+3:0]   total_q, total_d;
`endif

   // Writes are locked out for the whole scan so the radii stay coherent.
   sph_radius_buf #(
      .DEPTH (DEPTH),
      .W     (RADIUS_W)
   ) u_buf (
      .clk   (clk),
      .we    (wr_en && (state_q == IDLE)),
      .waddr (wr_addr),
      .wdata (wr_data),
      .raddr (idx_q),
      .rdata (rd_data)
   );

   assign start_cnt = sat_count(count, CNT_W'(DEPTH));

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      count_d    = count_q;
      wait_d     = wait_q;
      err_d      = err_q;
      res_area_d = res_area_q;
      res_idx_d  = res_idx_q;
      radius_d   = radius_q;
`ifdef SPH_SEQ_ACCUM_EN
      total_d    = total_q;
`endif
      core_en    = 1'b0;
      done       = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               err_d   = 1'b0;
               idx_d   = '0;
               count_d = start_cnt;
`ifdef SPH_SEQ_ACCUM_EN
               total_d = '0;
`endif
               state_d = (start_cnt == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            core_en  = 1'b1;
            radius_d = rd_data;
            wait_d   = '0;
            state_d  = WAIT;
         end
         WAIT: begin
            if (core_rdy) begin
               res_area_d = core_area;
               res_idx_d  = idx_q;
               state_d    = OUTPUT;
            end else if (wait_q == TO_W'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               wait_d = wait_q + TO_W'(1);
            end
         end
         OUTPUT: begin
            if (res_ready) begin
               idx_d = idx_q + IDX_W'(1);
`ifdef SPH_SEQ_ACCUM_EN
               total_d = total_q + (AREA_W+4)'(res_area_q);
`endif
               state_d = ((CNT_W'(idx_q) + CNT_W'(1)) == count_q) ? DONE : ISSUE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         count_q    <= '0;
         wait_q     <= '0;
         err_q      <= 1'b0;
         res_area_q <= '0;
         res_idx_q  <= '0;
         radius_q   <= '0;
`ifdef SPH_SEQ_ACCUM_EN
         total_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         count_q    <= count_d;
         wait_q     <= wait_d;
         err_q      <= err_d;
         res_area_q <= res_area_d;
         res_idx_q  <= res_idx_d;
         radius_q   <= radius_d;
`ifdef SPH_SEQ_ACCUM_EN
         total_q    <= total_d;
`endif
      end
   end

   // The live read is forwarded during ISSUE so a same-cycle write before start is seen.
   assign core_radius = (state_q == ISSUE) ? rd_data : radius_q;
   assign busy        = (state_q != IDLE);
   assign res_valid   = (state_q == OUTPUT);
   assign res_area    = res_area_q;
   assign res_idx     = res_idx_q;
   assign err_timeout = err_q;
`ifdef SPH_SEQ_ACCUM_EN
   assign total_area  = total_q;
`endif
endmodule

// File: doc/sph_scan_seq.md
SPH_SCAN_SEQ -- requirements
Module: sph_scan_seq

Interface
REQ-001 Parameters SHALL be: DEPTH, 16, radius buffer entries; RADIUS_W, 16, radius width; AREA_W, 26, area width; TIMEOUT, 255, max WAIT cycles before abort.
REQ-002 Clocking SHALL be one clock, clk; reset rst is synchronous and active-high.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 wr_en  in  1  buffer write strobe.
REQ-006 wr_addr  in  4  buffer write address.
REQ-007 wr_data  in  RADIUS_W  radius to store.
REQ-008 start  in  1  begin scan (single-cycle pulse).
REQ-009 count  in  5  entries to process (0..16).
REQ-010 busy  out  1  scan in progress.
REQ-011 done  out  1  one-cycle pulse at scan end.
REQ-012 err_timeout  out  1  sticky timeout flag.
REQ-013 core_en  out  1  issue strobe to Sphere_To_Cart en.
REQ-014 core_radius  out  RADIUS_W  radius to core.
REQ-015 core_rdy  in  1  core result valid.
REQ-016 core_area  in  AREA_W  core result.
REQ-017 res_valid  out  1  result available.
REQ-018 res_ready  in  1  downstream accepts result.
REQ-019 res_area  out  AREA_W  captured area.
REQ-020 res_idx  out  4  buffer index of result.

Function
REQ-021 FSM SHALL have states IDLE, ISSUE, WAIT, OUTPUT, DONE.
REQ-022 IDLE: start=1 and count>0 -> ISSUE with idx=0; start=1 and count=0 -> DONE; no results issued.
REQ-023 count values >16 SHALL saturate to 16; count is latched on start and later changes ignored.
REQ-024 ISSUE: core_en=1 for exactly one cycle, core_radius=buf[idx]; next state WAIT.
REQ-025 WAIT: core_rdy=1 -> capture core_area into res_area, idx into res_idx, go OUTPUT; core_rdy outside WAIT SHALL be ignored.
REQ-026 WAIT lasting TIMEOUT cycles without core_rdy -> err_timeout=1, go DONE, no result emitted.
REQ-027 OUTPUT: res_valid=1 held, res_area/res_idx stable until res_ready=1; on transfer idx+1; idx+1=count -> DONE, else ISSUE.
REQ-028 DONE: done=1 for one cycle, then IDLE.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 start while busy SHALL be ignored; wr_en while busy SHALL be ignored (buffer locked).
REQ-031 wr_en and start in the same IDLE cycle: write SHALL complete, scan SHALL use the new value.
REQ-032 err_timeout SHALL clear on the next accepted start.
REQ-033 Latency: start at cycle N -> core_en at N+1; core_rdy at M -> res_valid at M+1.
REQ-034 core_radius SHALL hold its last value outside ISSUE.

Reset
REQ-035 rst=1 SHALL force IDLE, idx=0, busy=0, done=0, core_en=0, res_valid=0, err_timeout=0, res_area=0, res_idx=0, core_radius=0 on the next edge, including mid-scan.
REQ-036 Buffer contents SHALL NOT be cleared by reset.

Configuration
REQ-037 Macro SPH_SEQ_ACCUM_EN defined: add output total_area (AREA_W+4 bits), cleared on accepted start, incremented by res_area on each res transfer, held after DONE, 0 on reset.
REQ-038 Macro undefined: total_area port and adder SHALL be absent.

Structure
REQ-039 Package sph_seq_pkg SHALL hold state enum, RADIUS_W/AREA_W/IDX_W constants and the area typedef.
REQ-040 Sub-module sph_radius_buf (DEPTH x RADIUS_W register file, 1 write, 1 async read) SHALL hold the radii.

Verification
REQ-041 Load 1000x4, 2000x4, 2500x4, 250x4; start count=16; core model rdy 3 cycles after en -> 16 results idx 0..15 in order, one done pulse.
REQ-042 count=0 start -> done pulse at cycle 2, no core_en, no res_valid.
REQ-043 res_ready low 10 cycles in OUTPUT -> res_area/res_idx stable, no new core_en.
REQ-044 Core never asserts rdy -> err_timeout=1 after 255 WAIT cycles, done pulse; next start clears flag.
REQ-045 rst at result 5 -> IDLE next cycle, busy=0; buffer readback unchanged.
REQ-046 SPH_SEQ_ACCUM_EN, core area=radius*2, 4 entries of 1000 -> total_area=8000.
